// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer for the HI/LO path.
// A 32-iteration shift-add multiplier and restoring divider share one
// accumulator pair. Both run on operand magnitudes, and the sign is fixed
// up on the last iteration.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mode         request valid (taken only in IDLE);
//                       mode 00 Mult, 01 Multu, 10 Div, 11 Divu
//   regaData, regbData  multiplicand/dividend, multiplier/divisor
//   cancel              flush; aborts an operation or squashes the write
//   stall, busy         pipeline hold request, state != IDLE
//   done, whi, wlo      one-cycle completion / HI,LO write enables
//   wHiData, wLoData    results, valid only during DONE (0 otherwise)
module muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] regaData,
  input  logic [DATA_W-1:0] regbData,
  input  logic              cancel,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              whi,
  output logic              wlo,
  output logic [DATA_W-1:0] wHiData,
  output logic [DATA_W-1:0] wLoData
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            st;
  logic [CNT_W-1:0]  cnt;
  // MUL: acc_hi = upper product, acc_lo = multiplier shifting out.
  // DIV: acc_hi = remainder,     acc_lo = dividend in / quotient out.
  logic [DATA_W-1:0] acc_hi, acc_lo, opnd;
  logic [DATA_W-1:0] res_hi, res_lo;
  logic              neg_q, neg_r;

  // operand magnitudes (sign only honoured in signed modes)
  logic              a_sgn, b_sgn;
  logic [DATA_W-1:0] a_mag, b_mag;
  assign a_sgn = !mode[0] && regaData[DATA_W-1];
  assign b_sgn = !mode[0] && regbData[DATA_W-1];
  assign a_mag = a_sgn ? -regaData : regaData;
  assign b_mag = b_sgn ? -regbData : regbData;

  // multiply step: 33-bit add keeps the carry, which shifts into the top bit
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_n = mul_sum[DATA_W:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[DATA_W-1:1]};

  // restoring divide step on the shifted {rem,quot} pair
  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              div_ge;
  logic [DATA_W-1:0] div_hi_n, div_lo_n;
  assign rem_sh   = {acc_hi, acc_lo[DATA_W-1]};
  assign rem_sub  = rem_sh - {1'b0, opnd};
  assign div_ge   = rem_sh >= {1'b0, opnd};
  assign div_hi_n = div_ge ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign div_lo_n = {acc_lo[DATA_W-2:0], div_ge};

  // sign fixup applied to the final-iteration values
  logic [2*DATA_W-1:0] prod_n, prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix;
  assign prod_n   = {mul_hi_n, mul_lo_n};
  assign prod_fix = neg_q ? -prod_n : prod_n;
  assign q_fix    = neg_q ? -div_lo_n : div_lo_n;
  assign r_fix    = neg_r ? -div_hi_n : div_hi_n;

  logic last;
  assign last = (cnt == CNT_W'(DATA_W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start && !cancel) begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          opnd   <= b_mag;
          cnt    <= '0;
          neg_q  <= a_sgn ^ b_sgn;
          neg_r  <= a_sgn;
          if (mode[1] && regbData == '0) begin
            // divide by zero: skip the iterations entirely
            res_hi <= regaData;
            res_lo <= '1;
            st     <= DONE;
          end else begin
            st <= mode[1] ? DIV : MUL;
          end
        end
        MUL: if (cancel) begin
          st <= IDLE;
        end else begin
          acc_hi <= mul_hi_n;
          acc_lo <= mul_lo_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            res_hi <= prod_fix[2*DATA_W-1:DATA_W];
            res_lo <= prod_fix[DATA_W-1:0];
            st     <= DONE;
          end
        end
        DIV: if (cancel) begin
          st <= IDLE;
        end else begin
          acc_hi <= div_hi_n;
          acc_lo <= div_lo_n;
          cnt    <= cnt + 1'b1;
          if (last) begin
            res_hi <= r_fix;
            res_lo <= q_fix;
            st     <= DONE;
          end
        end
        DONE:    st <= IDLE;  // start here is deliberately dropped
        default: st <= IDLE;
      endcase
    end
  end

  // stall covers the accept cycle combinationally and drops in DONE so the
  // instruction advances together with the HI/LO write
  assign stall   = (st == IDLE && start && !cancel) || st == MUL || st == DIV;
  assign busy    = (st != IDLE);
  assign done    = (st == DONE) && !cancel;
  assign whi     = done;
  assign wlo     = done;
  assign wHiData = (st == DONE) ? res_hi : '0;
  assign wLoData = (st == DONE) ? res_lo : '0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq. Inputs change 1 time unit after posedge,
// outputs are sampled on the negedge. Cycle 0 is the request cycle.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [1:0]  mode;
  logic [31:0] regaData, regbData;
  logic        stall, busy, done, whi, wlo;
  logic [31:0] wHiData, wLoData;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .regaData(regaData), .regbData(regbData), .cancel(cancel),
    .stall(stall), .busy(busy), .done(done), .whi(whi), .wlo(wlo),
    .wHiData(wHiData), .wLoData(wLoData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  // one request, fixed latency lat, operands scrambled after acceptance
  task automatic run_op(input string tag, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int lat);
    logic seen_early;
    seen_early = 1'b0;
    start = 1'b1; mode = m; regaData = a; regbData = b;
    @(negedge clk);
    chk({tag, "_acc_stall"}, stall, 1);
    nxt();
    start = 1'b0; regaData = $urandom; regbData = $urandom;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      if (!stall || done) seen_early = 1'b1;
      nxt();
    end
    if (lat > 1) chk({tag, "_busy_stall"}, seen_early, 0);
    @(negedge clk);
    chk({tag, "_done"}, {done, whi, wlo, stall, busy}, 5'b11101);
    chk({tag, "_hi"}, wHiData, ehi);
    chk({tag, "_lo"}, wLoData, elo);
    nxt();
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done, wHiData, wLoData}, '0);
    nxt();
  endtask

  // start a Mult, then abort at cycle 10 with cancel (use_rst=0) or rst
  task automatic abort_op(input string tag, input logic use_rst);
    logic wrote;
    wrote = 1'b0;
    start = 1'b1; mode = 2'b00; regaData = 32'd1234; regbData = 32'd5678;
    nxt();
    start = 1'b0;
    for (int c = 1; c < 10; c++) nxt();
    if (use_rst) rst = 1'b1; else cancel = 1'b1;
    @(negedge clk);
    chk({tag, "_stall_c10"}, {stall, whi, wlo}, 3'b100);
    nxt();
    rst = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_c11"}, {stall, busy}, 2'b00);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (whi || wlo || done) wrote = 1'b1;
      nxt();
    end
    chk({tag, "_no_write"}, wrote, 0);
  endtask

  initial begin
    int done_cnt, first_done, second_done;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; mode = 2'b00;
    regaData = '0; regbData = '0;
    nxt(); nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {stall, busy, done, whi, wlo, wHiData, wLoData}, '0);
    nxt();

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("mult_pos",  2'b00, 32'd100000,    32'd300000,    32'h0000_0006, 32'hFC23_AC00, 33);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu",      2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1);

    abort_op("cancel", 1'b0);
    abort_op("rst", 1'b1);

    // cancel together with start in IDLE: nothing accepted
    start = 1'b1; cancel = 1'b1; mode = 2'b01; regaData = 32'd3; regbData = 32'd5;
    @(negedge clk);
    chk("cancel_start_stall", stall, 0);
    nxt();
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_start_busy", busy, 0);
    nxt();

    // cancel during DONE squashes the write (divide by zero reaches DONE fast)
    start = 1'b1; mode = 2'b11; regaData = 32'd9; regbData = 32'd0;
    nxt();
    start = 1'b0; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_done", {busy, done, whi, wlo}, 4'b1000);
    nxt();
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_done_idle", busy, 0);
    nxt();

    // start held high: completions at 33 and 67, start in DONE ignored
    done_cnt = 0; first_done = -1; second_done = -1;
    start = 1'b1; mode = 2'b01; regaData = 32'd3; regbData = 32'd5;
    for (int c = 0; c <= 70; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c; else second_done = c;
        chk("b2b_lo", wLoData, 32'd15);
      end
      if (c == 33) chk("b2b_done_stall", {stall, busy}, 2'b01);
      if (c == 34) chk("b2b_reaccept", {stall, busy}, 2'b10);
      nxt();
    end
    chk("b2b_count", done_cnt, 2);
    chk("b2b_first", first_done, 33);
    chk("b2b_second", second_done, 67);
    start = 1'b0; cancel = 1'b1;
    nxt();
    cancel = 1'b0;
    @(negedge clk);
    chk("b2b_flush", {busy, stall}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the HI/LO path of the EX stage; replaces the single-cycle combinational mult/div.
- Accepts one Mult/Multu/Div/Divu request and runs a 32-iteration shift-add multiplier or restoring divider on operand magnitudes.
- Holds the pipeline through a stall output, then issues a one-cycle HI/LO write.
- Can be cancelled by exception/flush from the CP0 logic.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request valid; sampled only in IDLE.
- mode  in  2  00 Mult, 01 Multu, 10 Div, 11 Divu.
- regaData  in  DATA_W  multiplicand / dividend.
- regbData  in  DATA_W  multiplier / divisor.
- cancel  in  1  flush (exception/eret); aborts the operation.
- stall  out  1  pipeline hold request.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.
- whi  out  1  HI write enable.
- wlo  out  1  LO write enable.
- wHiData  out  DATA_W  HI result.
- wLoData  out  DATA_W  LO result.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst=1 at posedge): state=IDLE, counter=0, internal regs=0. All outputs are 0 while in IDLE with no request.
- IDLE
  - If start && !cancel at an edge, latch the operands. For signed modes, latch |a| and |b|, plus neg_q = a[31]^b[31] and neg_r = a[31].
  - Next state is MUL (mode[1]=0) or DIV (mode[1]=1), with counter=0.
  - Div/Divu with regbData==0 go directly to DONE: HI=regaData, LO=32'hFFFFFFFF.
- MUL
  - Each cycle: if multiplier LSB is set, add the multiplicand to the upper accumulator; then shift the 64-bit product right 1. The add carry is kept (33-bit add).
  - After 32 iterations (counter==31 edge), go to DONE.
  - Signed mode with neg_q set: the 64-bit product is two's-complement negated.
- DIV
  - Restoring division: shift the {rem,quot} pair left 1. If rem >= divisor, subtract and set quot LSB.
  - After 32 iterations, go to DONE.
  - Signed fixup: quotient negated if neg_q; remainder negated if neg_r.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
- DONE: lasts exactly one cycle.
  - done=whi=wlo=1 and wHiData/wLoData valid; next state IDLE.
  - A start in this cycle is ignored; the requester re-asserts it.
- Latency: start accepted at edge 0 → DONE during cycle 33 (2 cycles for divide-by-zero). Back-to-back throughput is one op per 34 cycles.
- stall = (IDLE && start && !cancel) || MUL || DIV.
  - Combinational, so the requesting instruction is held in the accept cycle.
  - stall=0 in DONE, so the instruction advances with the HI/LO write.
- busy = (state != IDLE).
- Outside DONE: whi=wlo=done=0 and wHiData=wLoData=0.
- cancel
  - In MUL/DIV: next state IDLE, no HI/LO write, stall drops in the following cycle.
  - In DONE: suppresses whi/wlo/done in that cycle.
  - cancel takes priority over start.
- rst mid-operation: state returns to IDLE next edge; no write occurs.
- Operands need not remain stable after acceptance.

Test Plan:
- Multu: a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle → stall high cycles 0-32; cycle 33 done=whi=wlo=1, HI=0xFFFFFFFE, LO=0x00000001.
- Mult: a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21). Div: a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divu: a=100, b=7 → LO=0x0000000E, HI=0x00000002. Div: a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: Divu, a=0x1234, b=0 → done in cycle 1, HI=0x00001234, LO=0xFFFFFFFF; stall high only in the accept cycle.
- cancel asserted in cycle 10 of a Mult → state IDLE at cycle 11, stall=0, no whi/wlo pulse at any later cycle. Repeat with rst=1 at cycle 10 → same result.
- start held high continuously → ops complete at cycles 33, 67, ...; start during DONE is ignored; cancel together with start in IDLE → no acceptance, stall=0.
